// File: rtl/factorial_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : factorial_ctrl_pkg
//  Brief    : Shared state encoding for the iterative factorial controller.
//  Revision : 1.0  initial release
// ============================================================================
package factorial_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : factorial_ctrl_pkg
`default_nettype wire

// File: rtl/factorial_ctrl_register.sv
`default_nettype none
// ============================================================================
//  Module   : register
//  Brief    : Plain load-enabled storage register; the controller decides
//             when it loads and what it loads (including the reset value).
//  Revision : 1.0  initial release
// ============================================================================
module register #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            load_reg,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    // Capture d on any edge where the controller asserts load_reg
    always_ff @(posedge clk) begin
        if (load_reg) begin
            q <= d;
        end
    end

endmodule : register
`default_nettype wire

// File: rtl/factorial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : factorial_ctrl
//  Brief    : Iterative n! engine on a go/done handshake. One multiply per
//             cycle into a product register, a down-counting count register,
//             and a sticky overflow flag when the true result exceeds SIZE.
//  Revision : 1.0  initial release
// ============================================================================
module factorial_ctrl
    import factorial_ctrl_pkg::*;
#(
    parameter int IN_WIDTH = 4,
    parameter int SIZE     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [IN_WIDTH-1:0] n,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [SIZE-1:0]     product
);

    localparam logic [SIZE-1:0]     c_prod_one = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic [IN_WIDTH-1:0] c_cnt_one  = {{(IN_WIDTH-1){1'b0}}, 1'b1};

    state_t                      r_state;
    state_t                      w_state_next;
    logic                        r_err;
    logic                        w_err_next;

    logic                        w_prod_load;
    logic [SIZE-1:0]             w_prod_d;
    logic [SIZE-1:0]             w_prod_q;
    logic                        w_cnt_load;
    logic [IN_WIDTH-1:0]         w_cnt_d;
    logic [IN_WIDTH-1:0]         w_cnt_q;

    logic [SIZE+IN_WIDTH-1:0]    w_full;
    logic                        w_ovf;
    logic                        w_cnt_le1;

    // Full-width product; any bit above SIZE means the true n! no longer fits
    assign w_full    = {{IN_WIDTH{1'b0}}, w_prod_q} * {{SIZE{1'b0}}, w_cnt_q};
    assign w_ovf     = |w_full[SIZE+IN_WIDTH-1:SIZE];
    assign w_cnt_le1 = (w_cnt_q <= c_cnt_one);

    register #(.SIZE(SIZE)) u_prod_reg (
        .clk      (clk),
        .load_reg (w_prod_load),
        .d        (w_prod_d),
        .q        (w_prod_q)
    );

    register #(.SIZE(IN_WIDTH)) u_cnt_reg (
        .clk      (clk),
        .load_reg (w_cnt_load),
        .d        (w_cnt_d),
        .q        (w_cnt_q)
    );

    // State and overflow flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_err   <= w_err_next;
        end
    end

    // Next state plus the load/data muxes feeding both registers
    always_comb begin
        w_state_next = r_state;
        w_err_next   = r_err;
        w_prod_load  = 1'b0;
        w_prod_d     = '0;
        w_cnt_load   = 1'b0;
        w_cnt_d      = '0;

        if (rst) begin
            // Storage has no reset of its own: clear it by loading zero
            w_state_next = S_IDLE;
            w_err_next   = 1'b0;
            w_prod_load  = 1'b1;
            w_cnt_load   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        w_prod_load  = 1'b1;
                        w_prod_d     = c_prod_one;
                        w_cnt_load   = 1'b1;
                        w_cnt_d      = n;
                        w_err_next   = 1'b0;
                        w_state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_cnt_le1) begin
                        w_state_next = S_DONE;
                    end else if (w_ovf) begin
                        // Keep the truncated value and stop immediately
                        w_prod_load  = 1'b1;
                        w_prod_d     = w_full[SIZE-1:0];
                        w_err_next   = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_prod_load  = 1'b1;
                        w_prod_d     = w_full[SIZE-1:0];
                        w_cnt_load   = 1'b1;
                        w_cnt_d      = w_cnt_q - c_cnt_one;
                    end
                end
                S_DONE: begin
                    if (!go) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign err     = r_err;
    assign product = w_prod_q;

endmodule : factorial_ctrl
`default_nettype wire

// File: tb/tb_factorial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_factorial_ctrl
//  Brief    : Self-checking bench for factorial_ctrl (directed + random ops
//             against an arithmetic factorial model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_factorial_ctrl;

    localparam int IN_WIDTH = 4;
    localparam int SIZE     = 8;
    localparam int LIMIT    = 40;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                go  = 1'b0;
    logic [IN_WIDTH-1:0] n   = '0;
    logic                busy;
    logic                done;
    logic                err;
    logic [SIZE-1:0]     product;

    int total = 0;
    int bad   = 0;

    factorial_ctrl #(.IN_WIDTH(IN_WIDTH), .SIZE(SIZE)) dut (
        .clk     (clk),
        .rst     (rst),
        .go      (go),
        .n       (n),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .product (product)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: multiply n*(n-1)*...*2 with plain integers; stop at the first
    // product that does not fit in SIZE bits. Latency counts edges from accept.
    task automatic model(input int nv, output int prod, output int ov, output int lat);
        int p;
        int idx;
        p   = 1;
        idx = 0;
        ov  = 0;
        lat = (nv <= 1) ? 2 : nv + 1;
        for (int k = nv; k >= 2; k--) begin
            idx++;
            p = p * k;
            if (p >= (1 << SIZE)) begin
                ov  = 1;
                p   = p % (1 << SIZE);
                lat = 1 + idx;
                break;
            end
        end
        prod = p;
    endtask

    // Full handshake: accept, wait for done, hold, release
    task automatic run_op(input int nv, input int hold);
        int exp_p, exp_e, exp_lat, cycles;
        model(nv, exp_p, exp_e, exp_lat);
        n  = nv[IN_WIDTH-1:0];
        go = 1'b1;
        step();
        cycles = 1;
        chk($sformatf("busy_after_accept n=%0d", nv), {31'd0, busy}, 32'd1);
        n = IN_WIDTH'($urandom);
        while (!done && cycles < LIMIT) begin
            step();
            cycles++;
        end
        chk($sformatf("latency n=%0d", nv), cycles, exp_lat);
        chk($sformatf("product n=%0d", nv), {24'd0, product}, exp_p);
        chk($sformatf("err n=%0d", nv), {31'd0, err}, exp_e);
        chk($sformatf("busy_in_done n=%0d", nv), {31'd0, busy}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk($sformatf("done_held n=%0d", nv), {31'd0, done}, 32'd1);
        end
        go = 1'b0;
        step();
        chk($sformatf("idle_done n=%0d", nv), {31'd0, done}, 32'd0);
        chk($sformatf("idle_busy n=%0d", nv), {31'd0, busy}, 32'd0);
        step();
        chk($sformatf("product_hold n=%0d", nv), {24'd0, product}, exp_p);
        chk($sformatf("err_hold n=%0d", nv), {31'd0, err}, exp_e);
    endtask

    initial begin
        int cycles;
        int saw_done;

        // Reset, then idle with go low
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_product", {24'd0, product}, 32'd0);
            chk("reset_done", {31'd0, done}, 32'd0);
            chk("reset_busy", {31'd0, busy}, 32'd0);
            chk("reset_err", {31'd0, err}, 32'd0);
        end

        // Directed: 5!, 0!, 1!, overflow at 6, err cleared by 3!
        run_op(5, 2);
        run_op(0, 1);
        run_op(1, 0);
        run_op(6, 1);
        run_op(3, 0);

        // Reset mid-computation abandons the operation
        n  = 4'd5;
        go = 1'b1;
        step();
        go = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_product", {24'd0, product}, 32'd0);
        saw_done = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) saw_done = 1;
        end
        chk("midrst_no_done", saw_done, 0);
        chk("midrst_product_later", {24'd0, product}, 32'd0);

        // Second go with a new n during RUN is ignored
        n  = 4'd4;
        go = 1'b1;
        step();
        go = 1'b0;
        step();
        n  = 4'd7;
        go = 1'b1;
        step();
        go = 1'b0;
        cycles = 3;
        while (!done && cycles < LIMIT) begin
            step();
            cycles++;
        end
        chk("ignore_go_latency", cycles, 5);
        chk("ignore_go_product", {24'd0, product}, 32'd24);
        chk("ignore_go_err", {31'd0, err}, 32'd0);
        step();
        chk("ignore_go_idle", {31'd0, done}, 32'd0);

        // Random operands across the full input range
        for (int t = 0; t < 25; t++) begin
            run_op($urandom_range(0, (1 << IN_WIDTH) - 1), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_factorial_ctrl
`default_nettype wire
